// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared types and defaults for the data-cache miss-handling logic.
//   - refill_state_t : states of the refill controller FSM
//   - DEFAULT_*      : default address/data widths
//   - needs_stall()  : an access that must leave IDLE (load miss or any store)
package cache_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int PERF_CNT_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    FILL   = 2'd3
  } refill_state_t;

  // Stores are write-through, so every store goes to memory; loads only on a miss.
  function automatic logic needs_stall(input logic access, input logic write, input logic hit);
    return access & (write | ~hit);
  endfunction

endpackage

// File: rtl/refill_perf_cnt.sv
// refill_perf_cnt
//   Load hit / load miss event counters for the refill controller.
//   Both counters wrap silently at 2^WIDTH.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     hit_evt      : one-cycle pulse per counted load hit
//     miss_evt     : one-cycle pulse per counted load miss
//     hit_cnt      : load hit count
//     miss_cnt     : load miss count
module refill_perf_cnt
  import cache_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_evt,
  input  logic             miss_evt,
  output logic [WIDTH-1:0] hit_cnt,
  output logic [WIDTH-1:0] miss_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (miss_evt) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Miss-handling controller between a direct-mapped data cache and main
//   memory. Load misses stall the pipeline, fetch the word over a valid/ack
//   handshake and write it into the cache line. Stores are write-through,
//   no-write-allocate; a store that hits also refreshes the cached copy.
//
//   Optional feature macro: CACHE_REFILL_PERF_EN
//     defined   -> adds hit_cnt_o / miss_cnt_o load hit/miss counters
//     undefined -> counters and ports absent
//
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     access_i, write_i   : CPU access valid / access is a store
//     addr_i, wdata_i     : access byte address (word aligned) / store data
//     hit_i               : cache hit flag for addr_i
//     stall_o             : freeze PC and pipeline registers
//     fill_o              : one-cycle cache line write strobe
//     fill_addr_o/data_o  : line address / data written into the cache
//     mem_req_o, mem_we_o : memory request valid / request is a write
//     mem_addr_o          : memory address
//     mem_wdata_o         : memory write data
//     mem_ack_i           : memory completes the request this cycle
//     mem_rdata_i         : read data, valid with mem_ack_i
//     hit_cnt_o/miss_cnt_o: (CACHE_REFILL_PERF_EN only) load hit/miss counts
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | watching CPU accesses; load hits pass without stalling
//   RD_REQ | load miss read outstanding to memory
//   WR_REQ | write-through store outstanding to memory
//   FILL   | one-cycle write of tag/data into the cache line
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  access_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  hit_i,
  output logic                  stall_o,
  output logic                  fill_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
`ifdef CACHE_REFILL_PERF_EN
  output logic [PERF_CNT_WIDTH-1:0] hit_cnt_o,
  output logic [PERF_CNT_WIDTH-1:0] miss_cnt_o,
`endif
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  refill_state_t         state;
  logic                  stall_q;
  logic                  store_hit_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  idle_detect;

  // Address is latched once per operation and serves both the memory
  // request and the subsequent line fill.
  assign mem_addr_o  = addr_q;
  assign fill_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign fill_data_o = fill_data_q;

  // The detect term is combinational from the CPU inputs, so it is masked by
  // rst to keep stall_o low for the whole time reset is held.
  assign idle_detect = (state == IDLE) && !rst && needs_stall(access_i, write_i, hit_i);
  assign stall_o     = stall_q | idle_detect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      stall_q     <= 1'b0;
      fill_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      store_hit_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_data_q <= '0;
    end else begin
      fill_o <= 1'b0;
      case (state)
        IDLE: begin
          if (access_i && !write_i && !hit_i) begin
            state       <= RD_REQ;
            addr_q      <= addr_i;
            store_hit_q <= 1'b0;
            stall_q     <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
          end else if (access_i && write_i) begin
            state       <= WR_REQ;
            addr_q      <= addr_i;
            wdata_q     <= wdata_i;
            store_hit_q <= hit_i;
            stall_q     <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
          end
        end

        RD_REQ: begin
          if (mem_ack_i) begin
            state       <= FILL;
            fill_data_q <= mem_rdata_i;
            fill_o      <= 1'b1;
            mem_req_o   <= 1'b0;
          end
        end

        WR_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (store_hit_q) begin
              state       <= FILL;
              fill_data_q <= wdata_q;
              fill_o      <= 1'b1;
            end else begin
              state   <= IDLE;
              stall_q <= 1'b0;
            end
          end
        end

        FILL: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          stall_q   <= 1'b0;
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_PERF_EN
  // After a load refill the CPU replays the same load, which now hits. That
  // replay belongs to the miss already counted, so it is not a new hit.
  logic replay_q;
  logic hit_evt;
  logic miss_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q <= 1'b0;
    end else begin
      replay_q <= (state == FILL) && !store_hit_q;
    end
  end

  assign hit_evt  = (state == IDLE) && access_i && !write_i && hit_i && !replay_q;
  assign miss_evt = (state == IDLE) && access_i && !write_i && !hit_i;

  refill_perf_cnt #(
    .WIDTH(PERF_CNT_WIDTH)
  ) u_perf_cnt (
    .clk      (clk),
    .rst      (rst),
    .hit_evt  (hit_evt),
    .miss_evt (miss_evt),
    .hit_cnt  (hit_cnt_o),
    .miss_cnt (miss_cnt_o)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        access_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        hit_i;
  logic        stall_o;
  logic        fill_o;
  logic [31:0] fill_addr_o;
  logic [31:0] fill_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cache_refill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .access_i    (access_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .hit_i       (hit_i),
    .stall_o     (stall_o),
    .fill_o      (fill_o),
    .fill_addr_o (fill_addr_o),
    .fill_data_o (fill_data_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
`ifdef CACHE_REFILL_PERF_EN
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o),
`endif
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one CPU access starting at posedge+1 and plays a memory that
  // acks `lat` cycles after mem_req_o rises. Loads stay presented and see a
  // hit once the fill has happened; stores are withdrawn after the detect
  // cycle. Ends at posedge+1 after the first cycle sampled with stall_o low.
  task automatic run_access(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        hit,
    input  int          lat,
    input  logic [31:0] rd,
    output int          stall_cnt,
    output int          fill_cnt,
    output int          fill_cyc,
    output logic [31:0] f_addr,
    output logic [31:0] f_data,
    output int          req_cnt,
    output logic        r_we,
    output logic [31:0] r_addr,
    output logic [31:0] r_wdata,
    output logic        unstable,
    output logic        timed_out
  );
    logic done;
    done = 1'b0;
    stall_cnt = 0; fill_cnt = 0; fill_cyc = -1; req_cnt = 0;
    f_addr = '0; f_data = '0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
    unstable = 1'b0;
    access_i = 1'b1; write_i = wr; addr_i = a; wdata_i = wd; hit_i = hit;
    mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0 && wr) access_i = 1'b0;
      if (!wr && fill_cnt > 0) hit_i = 1'b1;
      if (mem_req_o) begin
        if (req_cnt == 0) begin
          r_we = mem_we_o; r_addr = mem_addr_o; r_wdata = mem_wdata_o;
        end else if (mem_we_o !== r_we || mem_addr_o !== r_addr || mem_wdata_o !== r_wdata) begin
          unstable = 1'b1;
        end
        mem_ack_i   = (req_cnt == lat);
        mem_rdata_i = (req_cnt == lat) ? rd : 32'hA5A5_A5A5;
        req_cnt++;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hA5A5_A5A5;
      end
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (fill_o) begin
        fill_cnt++; fill_cyc = cyc; f_addr = fill_addr_o; f_data = fill_data_o;
      end
      if (!stall_o) done = 1'b1;
      @(posedge clk); #1;
    end
    timed_out = !done;
    access_i = 1'b0; write_i = 1'b0; hit_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    access_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0; hit_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    n_checks++; if (fill_o !== 1'b0) begin n_fail++; $display("FAIL reset_fill got %b exp 0", fill_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", mem_we_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata_o); end
    n_checks++; if (fill_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_fill_addr got %h exp 0", fill_addr_o); end
    n_checks++; if (fill_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_fill_data got %h exp 0", fill_data_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    run_access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 2, 32'hDEAD_BEEF,
               sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL load_miss_timeout got %b exp 0", to); end
    n_checks++; if (sc != 5) begin n_fail++; $display("FAIL load_miss_stall got %0d exp 5", sc); end
    n_checks++; if (fc != 1) begin n_fail++; $display("FAIL load_miss_fill_cnt got %0d exp 1", fc); end
    n_checks++; if (fa !== 32'h10) begin n_fail++; $display("FAIL load_miss_fill_addr got %h exp 00000010", fa); end
    n_checks++; if (fd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_miss_fill_data got %h exp deadbeef", fd); end
    n_checks++; if (rc != 3) begin n_fail++; $display("FAIL load_miss_req_cycles got %0d exp 3", rc); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL load_miss_we got %b exp 0", we); end
    n_checks++; if (ra !== 32'h10) begin n_fail++; $display("FAIL load_miss_req_addr got %h exp 00000010", ra); end
    n_checks++; if (un !== 1'b0) begin n_fail++; $display("FAIL load_miss_req_stable got %b exp 0", un); end
    n_checks++; if (fcy != 4) begin n_fail++; $display("FAIL load_miss_fill_cycle got %0d exp 4", fcy); end
  endtask

  task automatic test_load_hit;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    run_access(1'b0, 32'h0000_0020, 32'h0, 1'b1, 0, 32'h0,
               sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    n_checks++; if (sc != 0) begin n_fail++; $display("FAIL load_hit_stall got %0d exp 0", sc); end
    n_checks++; if (rc != 0) begin n_fail++; $display("FAIL load_hit_req got %0d exp 0", rc); end
    n_checks++; if (fc != 0) begin n_fail++; $display("FAIL load_hit_fill got %0d exp 0", fc); end
    // Two more idle cycles: still nothing happening on the memory side.
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL load_hit_idle_req got %b exp 0", mem_req_o); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_miss;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    run_access(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 0, 32'h0,
               sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL store_miss_timeout got %b exp 0", to); end
    n_checks++; if (sc != 2) begin n_fail++; $display("FAIL store_miss_stall got %0d exp 2", sc); end
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL store_miss_we got %b exp 1", we); end
    n_checks++; if (rw !== 32'h1234_5678) begin n_fail++; $display("FAIL store_miss_wdata got %h exp 12345678", rw); end
    n_checks++; if (ra !== 32'h40) begin n_fail++; $display("FAIL store_miss_addr got %h exp 00000040", ra); end
    n_checks++; if (fc != 0) begin n_fail++; $display("FAIL store_miss_fill got %0d exp 0", fc); end
    n_checks++; if (rc != 1) begin n_fail++; $display("FAIL store_miss_req_cycles got %0d exp 1", rc); end
  endtask

  task automatic test_store_hit;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    run_access(1'b1, 32'h0000_0044, 32'hCAFE_0001, 1'b1, 1, 32'h0,
               sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL store_hit_timeout got %b exp 0", to); end
    n_checks++; if (sc != 4) begin n_fail++; $display("FAIL store_hit_stall got %0d exp 4", sc); end
    n_checks++; if (fc != 1) begin n_fail++; $display("FAIL store_hit_fill_cnt got %0d exp 1", fc); end
    n_checks++; if (fd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL store_hit_fill_data got %h exp cafe0001", fd); end
    n_checks++; if (fa !== 32'h44) begin n_fail++; $display("FAIL store_hit_fill_addr got %h exp 00000044", fa); end
    n_checks++; if (fcy != 3) begin n_fail++; $display("FAIL store_hit_fill_cycle got %0d exp 3", fcy); end
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL store_hit_we got %b exp 1", we); end
    n_checks++; if (un !== 1'b0) begin n_fail++; $display("FAIL store_hit_req_stable got %b exp 0", un); end
  endtask

  task automatic test_reset_mid_read;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    access_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0080; hit_i = 1'b0; mem_ack_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL midrst_req_before got %b exp 1", mem_req_o); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b exp 0", mem_req_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %b exp 0", stall_o); end
    n_checks++; if (fill_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fill got %b exp 0", fill_o); end
    @(posedge clk); #1;
    rst = 1'b0; access_i = 1'b0;
    // Idle after release: no request reissued, no stall.
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
        n_fail++; $display("FAIL midrst_idle got req=%b stall=%b exp 0 0", mem_req_o, stall_o);
      end
      @(posedge clk); #1;
    end
    // A fresh load miss with an immediate ack runs normally afterwards.
    run_access(1'b0, 32'h0000_0084, 32'h0, 1'b0, 0, 32'h0BAD_F00D,
               sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    n_checks++; if (sc != 3) begin n_fail++; $display("FAIL midrst_reload_stall got %0d exp 3", sc); end
    n_checks++; if (fd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL midrst_reload_data got %h exp 0badf00d", fd); end
    n_checks++; if (fa !== 32'h84) begin n_fail++; $display("FAIL midrst_reload_addr got %h exp 00000084", fa); end
  endtask

  task automatic test_ack_in_idle;
    access_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (mem_req_o !== 1'b0 || fill_o !== 1'b0 || stall_o !== 1'b0) begin
        n_fail++; $display("FAIL idle_ack got req=%b fill=%b stall=%b exp 0 0 0", mem_req_o, fill_o, stall_o);
      end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
  endtask

`ifdef CACHE_REFILL_PERF_EN
  task automatic test_perf_cnt;
    int sc, fc, fcy, rc; logic [31:0] fa, fd, ra, rw; logic we, un, to;
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b1, 0, 32'h0,
                 sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    end
    for (int i = 0; i < 2; i++) begin
      run_access(1'b0, 32'h200 + 32'(4 * i), 32'h0, 1'b0, 1, 32'h5555_0000,
                 sc, fc, fcy, fa, fd, rc, we, ra, rw, un, to);
    end
    @(negedge clk);
    n_checks++; if (hit_cnt_o !== 32'd3) begin n_fail++; $display("FAIL perf_hit_cnt got %0d exp 3", hit_cnt_o); end
    n_checks++; if (miss_cnt_o !== 32'd2) begin n_fail++; $display("FAIL perf_miss_cnt got %0d exp 2", miss_cnt_o); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_miss();
    test_store_hit();
    test_reset_mid_read();
    test_ack_in_idle();
`ifdef CACHE_REFILL_PERF_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
